// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with registered read data, one-cycle handshake/error pulses,
// synchronous flush and live-programmable almost-full/almost-empty thresholds.
`timescale 1ns/1ps
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic [AW:0]           af_thresh,
  input  logic [AW:0]           ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [AW:0]           count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_accept;
  logic                  rd_accept;

  always_comb begin
    full        = (count == DEPTH_C);
    empty       = (count == '0);
    // A threshold above the depth can never be reached, so almostfull stays low.
    almostfull  = (count >= af_thresh);
    almostempty = (count <= ae_thresh);
    wr_accept   = wr_en && !full  && !flush;
    rd_accept   = rd_en && !empty && !flush;
  end

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_accept;
      rd_valid  <= rd_accept;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      unique case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: queue-based reference model checked on every
// falling edge, plus literal expectations at key points of each scenario.
`timescale 1ns/1ps
module tb_sync_fifo_prog;

  localparam int W = 16;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0;
  logic [3:0]    af_thresh = 4'd6, ae_thresh = 4'd1;
  logic [W-1:0]  data_out;
  logic          rd_valid, wr_ack, overflow, underflow;
  logic          full, empty, almostfull, almostempty;
  logic [3:0]    count;

  int n_vec = 0;
  int n_mis = 0;

  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .data_out(data_out), .rd_valid(rd_valid), .wr_ack(wr_ack),
    .overflow(overflow), .underflow(underflow), .full(full), .empty(empty),
    .almostfull(almostfull), .almostempty(almostempty), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, pulses from the previous edge's decisions.
  logic [W-1:0] q [$];
  logic [W-1:0] m_dout = '0;
  logic m_wack = 0, m_rv = 0, m_ovf = 0, m_udf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_dout = '0;
      {m_wack, m_rv, m_ovf, m_udf} = '0;
    end else if (flush) begin
      q.delete();
      {m_wack, m_rv, m_ovf, m_udf} = '0;
    end else begin
      automatic int  sz   = q.size();
      automatic bit  w_ok = wr_en && sz < D;
      automatic bit  r_ok = rd_en && sz > 0;
      m_wack = w_ok;
      m_rv   = r_ok;
      m_ovf  = wr_en && !w_ok;
      m_udf  = rd_en && !r_ok;
      if (r_ok) m_dout = q.pop_front();
      if (w_ok) q.push_back(data_in);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic int sz = q.size();
    chk("m_data_out",    data_out,    m_dout);
    chk("m_rd_valid",    rd_valid,    m_rv);
    chk("m_wr_ack",      wr_ack,      m_wack);
    chk("m_overflow",    overflow,    m_ovf);
    chk("m_underflow",   underflow,   m_udf);
    chk("m_count",       count,       sz);
    chk("m_full",        full,        sz == D);
    chk("m_empty",       empty,       sz == 0);
    chk("m_almostfull",  almostfull,  sz >= int'(af_thresh));
    chk("m_almostempty", almostempty, sz <= int'(ae_thresh));
  end

  task automatic cyc(input logic w, input logic r, input logic [W-1:0] d);
    wr_en = w; rd_en = r; data_in = d;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; flush = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full,  0);
    chk("rst_dout",  data_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, W'(i));
      chk("fill_wack", wr_ack, 1);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);

    cyc(1, 0, 16'hDEAD);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 8);
    cyc(0, 0, '0);
    chk("ovf_clear", overflow, 0);

    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, '0);
      chk("drain_data", data_out, i);
      chk("drain_rv", rd_valid, 1);
    end
    chk("drain_empty", empty, 1);

    cyc(0, 1, '0);
    chk("udf_pulse", underflow, 1);
    chk("udf_dout", data_out, 16'h0008);

    for (int i = 0; i < 4; i++) cyc(1, 0, W'(16'h11 + i));
    cyc(1, 1, 16'h15);
    chk("sim4_count", count, 4);
    chk("sim4_wack", wr_ack, 1);
    chk("sim4_rv", rd_valid, 1);
    chk("sim4_dout", data_out, 16'h11);
    for (int i = 0; i < 4; i++) cyc(1, 0, W'(16'h16 + i));
    cyc(1, 1, 16'hAA);
    chk("sim8_count", count, 7);
    chk("sim8_ovf", overflow, 1);
    chk("sim8_rv", rd_valid, 1);
    chk("sim8_dout", data_out, 16'h12);
    for (int i = 0; i < 7; i++) cyc(0, 1, '0);
    chk("sim8_last", data_out, 16'h19);
    cyc(1, 1, 16'h33);
    chk("sim0_count", count, 1);
    chk("sim0_udf", underflow, 1);
    chk("sim0_wack", wr_ack, 1);
    chk("sim0_rv", rd_valid, 0);
    cyc(0, 1, '0);
    chk("sim0_dout", data_out, 16'h33);
    chk("sim0_empty", empty, 1);

    for (int c = 0; c <= 8; c++) begin
      chk("thr_ae", almostempty, c <= 1);
      chk("thr_af", almostfull, c >= 6);
      if (c < 8) cyc(1, 0, W'(16'h40 + c));
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, '0);
    af_thresh = 4'd3; #1;
    chk("thr_af3", almostfull, 1);
    af_thresh = 4'd15; #1;
    chk("thr_af15", almostfull, 0);
    af_thresh = 4'd6;
    for (int i = 0; i < 4; i++) cyc(0, 1, '0);

    for (int i = 0; i < 20; i++) begin
      automatic logic [W-1:0] d = W'($urandom);
      cyc(1, 0, d);
      cyc(0, 1, '0);
      chk("wrap_data", data_out, d);
    end

    for (int i = 0; i < 5; i++) cyc(1, 0, W'(16'h60 + i));
    chk("flush_pre", count, 5);
    flush = 1'b1;
    cyc(1, 0, 16'h77);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_wack", wr_ack, 0);

    cyc(1, 0, 16'hA1);
    cyc(1, 0, 16'hA2);
    cyc(1, 0, 16'hA3);
    #1 rst_n = 1'b0;
    #0.5;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_dout", data_out, 0);
    chk("arst_pulses", {wr_ack, rd_valid, overflow, underflow}, 0);
    #0.5 rst_n = 1'b1;
    cyc(1, 0, 16'hBEEF);
    cyc(0, 1, '0);
    chk("arst_fresh", data_out, 16'hBEEF);
    chk("arst_after", count, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
